regs_wport_arbiter: RTL and testbench
=====================================

Name: regs_wport_arbiter

Overview:
- Sole owner of the pMIPS register file's single write port and its two read-address inputs.
- The register file (32 x n style, %0 == 0, 8 entries addressed by 3 bits) writes through `Raddr2` when `w=1`, so write address and second read address share one bus.
- This block sequences a post-reset clear of r1..r7, then arbitrates each cycle between CPU writeback and a host/debug loader, muxing `Raddr2` accordingly.
- A starvation counter guarantees host progress by stalling the CPU.

Parameters:
- `n`, 8, register data width.
- `MAXWAIT`, 4, consecutive cycles a host request may be denied before the host is forced through (range 1..15).

Ports:
- `clk` in 1: system clock, all state on posedge.
- `reset` in 1: synchronous, active-high.
- `cpu_w` in 1: CPU writeback request this cycle.
- `cpu_waddr` in 3: CPU destination register.
- `cpu_wdata` in n: CPU writeback data.
- `cpu_raddr1` in 3: CPU read address, port 1.
- `cpu_raddr2` in 3: CPU read address, port 2.
- `host_req` in 1: host write request, held until acked.
- `host_addr` in 3: host destination register.
- `host_data` in n: host write data.
- `host_ack` out 1: one-cycle pulse, host write performed this cycle.
- `stall` out 1: CPU must hold its current instruction this cycle.
- `busy` out 1: clear sequence in progress.
- `w` out 1: register-file write enable.
- `Wdata` out n: register-file write data.
- `Raddr1` out 3: register-file read address 1.
- `Raddr2` out 3: register-file read address 2 / write address.

Behaviour:
- Registered state: `state` in {CLEAR, RUN}, clear counter `ccnt[2:0]`, wait counter `wcnt[3:0]`. Every other output is a combinational function of state and inputs.
- While `reset=1` (sampled at posedge): `state<=CLEAR`, `ccnt<=1`, `wcnt<=0`.
- Output values while in CLEAR: `busy=1`, `stall=1`, `host_ack=0`, `w=1`, `Wdata=0`, `Raddr2=ccnt`, `Raddr1=0`.
- Reset asserted mid-operation restarts the clear from r1. No partial host or CPU write survives into the next cycle.
- CLEAR sequence: `ccnt` increments 1..7 (7 cycles). On the cycle `ccnt==7`, `state<=RUN`. r0 is never written.
- RUN, write-source decision per cycle:
  - `force = host_req && (wcnt >= MAXWAIT)`.
  - If `force`: host wins. `stall=1`. CPU write suppressed; the CPU re-issues next cycle.
  - Else if `cpu_w`: CPU wins. `w=1`, `Raddr2=cpu_waddr`, `Wdata=cpu_wdata`, `stall=0`. Host is denied.
  - Else if `host_req`: host wins, no stall.
  - Else: idle, `w=0`, `Raddr2=cpu_raddr2`, `Wdata=cpu_wdata`.
- Host win: `w=1`, `Raddr2=host_addr`, `Wdata=host_data`, `host_ack=1`.
- `Raddr1=cpu_raddr1` always in RUN.
- Address 0: any write targeting address 0 (CPU or host) drives `w=0`. The grant still counts; `host_ack` still pulses, so the host completes.
- `wcnt` update:
  - Cleared on `host_ack` or when `host_req=0`.
  - Incremented when `host_req=1` and the host is denied.
  - Saturates at 15.
- Latency: a write is committed at the posedge ending the granted cycle. Readback via `Raddr1` is valid from the next cycle.
- `host_ack` is never asserted in consecutive cycles for one request. The host must drop or change its request after an ack. If `host_req` stays high, the next cycle is treated as a new request.
- `stall=0` whenever `state==RUN` and the host is not forced.

Test Plan:
1. Reset for 2 cycles then release → `busy=1` for exactly 7 cycles with `Raddr2` = 1,2,…,7, `w=1`, `Wdata=0`. Then `busy=0`; reading r1..r7 returns 0.
2. RUN, `cpu_w=1`, `cpu_waddr=3`, `cpu_wdata=8'h07` → `w=1`, `Raddr2=3` that cycle. Next cycle `Raddr1=3` reads `8'h07`. `stall=0`.
3. `cpu_w=1` and `cpu_waddr=0`, `cpu_wdata=8'hFF` → `w=0`. r0 still reads 0.
4. `host_req=1` (addr 5, data `8'h2A`) with `cpu_w=0` → `host_ack=1` the same cycle, `w=1`, `Raddr2=5`. r5 reads `8'h2A` next cycle.
5. `host_req=1` with `cpu_w=1` every cycle, `MAXWAIT=4` → host denied 4 cycles (`stall=0`). Cycle 5: `stall=1`, `host_ack=1`, host data written, CPU write suppressed. Then `wcnt=0`.
6. Assert `reset` during a forced host grant → no `host_ack` that cycle. Clear sequence restarts at r1; all r1..r7 read 0 after 7 cycles.

Source files
------------

// File: rtl/regs_wport_arbiter.sv
// Write-port and read-address arbiter for the pMIPS 8-entry register file.
// Clears r1..r7 after reset, then arbitrates CPU writeback against a host loader.
module regs_wport_arbiter #(
    parameter int n       = 8,
    parameter int MAXWAIT = 4
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         cpu_w,
    input  logic [2:0]   cpu_waddr,
    input  logic [n-1:0] cpu_wdata,
    input  logic [2:0]   cpu_raddr1,
    input  logic [2:0]   cpu_raddr2,
    input  logic         host_req,
    input  logic [2:0]   host_addr,
    input  logic [n-1:0] host_data,
    output logic         host_ack,
    output logic         stall,
    output logic         busy,
    output logic         w,
    output logic [n-1:0] Wdata,
    output logic [2:0]   Raddr1,
    output logic [2:0]   Raddr2
);

    typedef enum logic {
        CLEAR = 1'b0,
        RUN   = 1'b1
    } state_t;

    localparam logic [3:0] MAXWAIT_W = 4'(MAXWAIT);
    localparam logic [3:0] WCNT_MAX  = 4'd15;

    state_t     state_reg, state_next;
    logic [2:0] ccnt_reg, ccnt_next;
    logic [3:0] wcnt_reg, wcnt_next;

    logic       force_host;
    logic       host_grant;
    logic       cpu_grant;

    assign force_host = host_req && (wcnt_reg >= MAXWAIT_W);

    // Grant and register-file port muxing. Reset is honoured combinationally
    // so that no write or ack escapes during the cycle reset is asserted.
    always_comb begin
        busy       = 1'b0;
        stall      = 1'b0;
        host_ack   = 1'b0;
        w          = 1'b0;
        Wdata      = cpu_wdata;
        Raddr1     = cpu_raddr1;
        Raddr2     = cpu_raddr2;
        host_grant = 1'b0;
        cpu_grant  = 1'b0;

        if (reset) begin
            busy   = 1'b1;
            stall  = 1'b1;
            Wdata  = '0;
            Raddr1 = 3'd0;
            Raddr2 = 3'd0;
        end else if (state_reg == CLEAR) begin
            busy   = 1'b1;
            stall  = 1'b1;
            w      = 1'b1;
            Wdata  = '0;
            Raddr1 = 3'd0;
            Raddr2 = ccnt_reg;
        end else begin
            if (force_host) begin
                host_grant = 1'b1;
                stall      = 1'b1;
            end else if (cpu_w) begin
                cpu_grant  = 1'b1;
            end else if (host_req) begin
                host_grant = 1'b1;
            end

            // r0 is hardwired zero: the grant is consumed but nothing is written.
            if (host_grant) begin
                host_ack = 1'b1;
                Raddr2   = host_addr;
                Wdata    = host_data;
                w        = (host_addr != 3'd0);
            end else if (cpu_grant) begin
                Raddr2   = cpu_waddr;
                Wdata    = cpu_wdata;
                w        = (cpu_waddr != 3'd0);
            end
        end
    end

    always_comb begin
        state_next = state_reg;
        ccnt_next  = ccnt_reg;

        if (state_reg == CLEAR) begin
            if (ccnt_reg == 3'd7) begin
                state_next = RUN;
            end else begin
                ccnt_next = ccnt_reg + 3'd1;
            end
        end

        if (!host_req || host_ack) begin
            wcnt_next = 4'd0;
        end else if (wcnt_reg != WCNT_MAX) begin
            wcnt_next = wcnt_reg + 4'd1;
        end else begin
            wcnt_next = wcnt_reg;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_reg <= CLEAR;
            ccnt_reg  <= 3'd1;
            wcnt_reg  <= 4'd0;
        end else begin
            state_reg <= state_next;
            ccnt_reg  <= ccnt_next;
            wcnt_reg  <= wcnt_next;
        end
    end

endmodule

// File: tb/tb_regs_wport_arbiter.sv
// Directed bench for regs_wport_arbiter with a behavioural 8-entry register file
// attached to its write port and read address 1.
module tb_regs_wport_arbiter;

    localparam int N = 8;

    logic         clk = 1'b0;
    logic         reset;
    logic         cpu_w;
    logic [2:0]   cpu_waddr;
    logic [N-1:0] cpu_wdata;
    logic [2:0]   cpu_raddr1;
    logic [2:0]   cpu_raddr2;
    logic         host_req;
    logic [2:0]   host_addr;
    logic [N-1:0] host_data;
    logic         host_ack;
    logic         stall;
    logic         busy;
    logic         w;
    logic [N-1:0] Wdata;
    logic [2:0]   Raddr1;
    logic [2:0]   Raddr2;

    int n_vec = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    regs_wport_arbiter #(.n(N), .MAXWAIT(4)) dut (
        .clk        (clk),
        .reset      (reset),
        .cpu_w      (cpu_w),
        .cpu_waddr  (cpu_waddr),
        .cpu_wdata  (cpu_wdata),
        .cpu_raddr1 (cpu_raddr1),
        .cpu_raddr2 (cpu_raddr2),
        .host_req   (host_req),
        .host_addr  (host_addr),
        .host_data  (host_data),
        .host_ack   (host_ack),
        .stall      (stall),
        .busy       (busy),
        .w          (w),
        .Wdata      (Wdata),
        .Raddr1     (Raddr1),
        .Raddr2     (Raddr2)
    );

    // Register file model: writes whatever the port says, even to r0, so a
    // stray r0 write shows up on readback. Non-zero power-up contents.
    logic [N-1:0] rf [8];
    logic [N-1:0] rdata1;

    initial begin
        rf[0] = '0;
        for (int i = 1; i < 8; i++) rf[i] = 8'hA5;
    end

    always @(posedge clk) begin
        if (w) rf[Raddr2] <= Wdata;
    end

    assign rdata1 = rf[Raddr1];

    task automatic chk(input string tag, input logic [15:0] got, input logic [15:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end else begin
            $display("ok   %s: %0h", tag, got);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        cpu_w      = 1'b0;
        cpu_waddr  = 3'd0;
        cpu_wdata  = '0;
        cpu_raddr1 = 3'd0;
        cpu_raddr2 = 3'd0;
        host_req   = 1'b0;
        host_addr  = 3'd0;
        host_data  = '0;
    endtask

    task automatic check_clear_seq(input string tag);
        for (int i = 1; i <= 7; i++) begin
            @(negedge clk);
            chk({tag, " busy"},   16'(busy),   16'd1);
            chk({tag, " raddr2"}, 16'(Raddr2), 16'(i));
            chk({tag, " w"},      16'(w),      16'd1);
            chk({tag, " wdata"},  16'(Wdata),  16'd0);
            chk({tag, " stall"},  16'(stall),  16'd1);
            tick();
        end
    endtask

    task automatic check_all_zero(input string tag);
        for (int i = 1; i <= 7; i++) begin
            cpu_raddr1 = 3'(i);
            @(negedge clk);
            chk({tag, " busy"},  16'(busy),   16'd0);
            chk({tag, " rd"},    16'(rdata1), 16'd0);
            tick();
        end
        cpu_raddr1 = 3'd0;
    endtask

    initial begin
        idle_inputs();
        reset = 1'b1;

        // 1: reset, clear sequence, readback zero
        for (int i = 0; i < 2; i++) begin
            @(negedge clk);
            chk("rst busy", 16'(busy),     16'd1);
            chk("rst ack",  16'(host_ack), 16'd0);
            tick();
        end
        reset = 1'b0;
        check_clear_seq("clr1");
        check_all_zero("zero1");

        // 2: CPU write r3 = 07
        cpu_w = 1'b1; cpu_waddr = 3'd3; cpu_wdata = 8'h07;
        @(negedge clk);
        chk("cpu w",      16'(w),      16'd1);
        chk("cpu raddr2", 16'(Raddr2), 16'd3);
        chk("cpu wdata",  16'(Wdata),  16'h07);
        chk("cpu stall",  16'(stall),  16'd0);
        tick();
        idle_inputs(); cpu_raddr1 = 3'd3; cpu_raddr2 = 3'd6;
        @(negedge clk);
        chk("idle w",      16'(w),      16'd0);
        chk("idle raddr2", 16'(Raddr2), 16'd6);
        chk("r3 rd",       16'(rdata1), 16'h07);
        tick();

        // 3: CPU write to r0 is dropped
        idle_inputs(); cpu_w = 1'b1; cpu_waddr = 3'd0; cpu_wdata = 8'hFF;
        @(negedge clk);
        chk("cpu r0 w",     16'(w),     16'd0);
        chk("cpu r0 stall", 16'(stall), 16'd0);
        tick();
        idle_inputs(); cpu_raddr1 = 3'd0;
        @(negedge clk);
        chk("r0 rd", 16'(rdata1), 16'd0);
        tick();

        // 4: host write r5 = 2A with CPU idle
        host_req = 1'b1; host_addr = 3'd5; host_data = 8'h2A;
        @(negedge clk);
        chk("host ack",    16'(host_ack), 16'd1);
        chk("host w",      16'(w),        16'd1);
        chk("host raddr2", 16'(Raddr2),   16'd5);
        chk("host wdata",  16'(Wdata),    16'h2A);
        chk("host stall",  16'(stall),    16'd0);
        tick();
        idle_inputs(); cpu_raddr1 = 3'd5;
        @(negedge clk);
        chk("host ack drop", 16'(host_ack), 16'd0);
        chk("r5 rd",         16'(rdata1),   16'h2A);
        tick();

        // host write to r0: acked but not written
        idle_inputs(); host_req = 1'b1; host_addr = 3'd0; host_data = 8'h99;
        @(negedge clk);
        chk("host r0 ack", 16'(host_ack), 16'd1);
        chk("host r0 w",   16'(w),        16'd0);
        tick();

        // 5: starvation, host forced through on the 5th cycle
        idle_inputs();
        cpu_w = 1'b1; cpu_waddr = 3'd2; cpu_wdata = 8'h11;
        host_req = 1'b1; host_addr = 3'd6; host_data = 8'h3C;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            chk("deny ack",    16'(host_ack), 16'd0);
            chk("deny stall",  16'(stall),    16'd0);
            chk("deny raddr2", 16'(Raddr2),   16'd2);
            tick();
        end
        @(negedge clk);
        chk("force stall",  16'(stall),    16'd1);
        chk("force ack",    16'(host_ack), 16'd1);
        chk("force w",      16'(w),        16'd1);
        chk("force raddr2", 16'(Raddr2),   16'd6);
        chk("force wdata",  16'(Wdata),    16'h3C);
        tick();
        // request held: counter restarted, so it is denied again
        @(negedge clk);
        chk("post ack",    16'(host_ack), 16'd0);
        chk("post stall",  16'(stall),    16'd0);
        chk("post raddr2", 16'(Raddr2),   16'd2);
        tick();
        idle_inputs(); cpu_raddr1 = 3'd6;
        @(negedge clk);
        chk("r6 rd", 16'(rdata1), 16'h3C);
        cpu_raddr1 = 3'd2;
        #1;
        chk("r2 rd", 16'(rdata1), 16'h11);
        tick();

        // 6: reset during forced grant
        idle_inputs();
        cpu_w = 1'b1; cpu_waddr = 3'd4; cpu_wdata = 8'h55;
        host_req = 1'b1; host_addr = 3'd7; host_data = 8'h77;
        for (int i = 0; i < 4; i++) tick();
        @(negedge clk);
        chk("pre-rst force", 16'(host_ack), 16'd1);
        reset = 1'b1;
        #1;
        chk("rst force ack", 16'(host_ack), 16'd0);
        chk("rst force w",   16'(w),        16'd0);
        tick();
        reset = 1'b0;
        idle_inputs();
        check_clear_seq("clr2");
        check_all_zero("zero2");

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: bench did not finish");
        $fatal(1);
    end

endmodule
